// File: rtl/uart_cmd_decoder_if.sv
// Byte-stream input and register/ACK outputs of uart_cmd_decoder.
// slave = the decoder, master = the UART_RX / PID side that feeds and consumes it.
interface uart_cmd_decoder_if #(
   parameter int NUM_GAINS = 3,
   parameter int GAIN_W    = 36
);
   logic                        i_RX_DV;
   logic [7:0]                  i_RX_Byte;
   logic [NUM_GAINS*GAIN_W-1:0] o_gains;
   logic [7:0]                  o_ctrl;
   logic                        o_wr_pulse;
   logic [7:0]                  o_wr_addr;
   logic                        o_err_pulse;
   logic [1:0]                  o_err_code;
   logic                        o_ack_dv;
   logic [7:0]                  o_ack_byte;

   modport master (
      output i_RX_DV, i_RX_Byte,
      input  o_gains, o_ctrl, o_wr_pulse, o_wr_addr,
             o_err_pulse, o_err_code, o_ack_dv, o_ack_byte
   );

   modport slave (
      input  i_RX_DV, i_RX_Byte,
      output o_gains, o_ctrl, o_wr_pulse, o_wr_addr,
             o_err_pulse, o_err_code, o_ack_dv, o_ack_byte
   );
endinterface

// File: rtl/uart_cmd_decoder.sv
// Framed register-write decoder: SOF, addr, DATA_BYTES payload (MSB first), [CSUM], EOF -> write + ACK/NAK.
// Optional checksum byte before EOF is enabled by defining UART_CMD_CHECKSUM_EN.
module uart_cmd_decoder #(
   parameter int         NUM_GAINS    = 3,
   parameter int         GAIN_W       = 36,
   parameter int         DATA_BYTES   = 5,
   parameter logic [7:0] SOF_BYTE     = 8'hAA,
   parameter logic [7:0] EOF_BYTE     = 8'hBB,
   parameter int         TIMEOUT_CLKS = 50000
) (
   input logic               i_Clk,
   input logic               i_Rst_n,
   uart_cmd_decoder_if.slave bus
);
   localparam int               KEEP_W    = (GAIN_W > 8) ? GAIN_W : 8;
   localparam int               CNT_W     = $clog2(TIMEOUT_CLKS + 1);
   localparam int               BC_W      = $clog2(DATA_BYTES + 1);
   localparam logic [CNT_W-1:0] TO_LAST   = CNT_W'(TIMEOUT_CLKS - 1);
   localparam logic [BC_W-1:0]  DATA_LAST = BC_W'(DATA_BYTES - 1);
   localparam logic [7:0]       MAX_ADDR  = 8'(NUM_GAINS);
   localparam logic [7:0]       ACK_BYTE  = 8'h06;
   localparam logic [7:0]       NAK_BYTE  = 8'h15;
   localparam logic [1:0]       ERR_ADDR  = 2'd1;
   localparam logic [1:0]       ERR_EOF   = 2'd2;
   localparam logic [1:0]       ERR_CHECK = 2'd3;

   typedef enum logic [2:0] {ST_IDLE, ST_ADDR, ST_DATA, ST_CSUM, ST_EOF} state_t;

   state_t                      state_q;
   logic [1:0]                  rstSync_q;
   logic                        rstInt_n;
   logic [7:0]                  addr_q;
   logic [KEEP_W-1:0]           payload_q;
   logic [KEEP_W-1:0]           payload_d;
   logic [BC_W-1:0]             byteCnt_q;
   logic [CNT_W-1:0]            timeoutCnt_q;
   logic [CNT_W-1:0]            timeoutCnt_d;
   logic                        timeoutHit;
   logic                        csumBad;
   logic [NUM_GAINS*GAIN_W-1:0] gains_q;
   logic [7:0]                  ctrl_q;
   logic                        wrPulse_q;
   logic [7:0]                  wrAddr_q;
   logic                        errPulse_q;
   logic [1:0]                  errCode_q;
   logic                        ackDv_q;
   logic [7:0]                  ackByte_q;
`ifdef UART_CMD_CHECKSUM_EN
   logic [7:0]                  csum_q;
`endif

   // Reset asserts immediately but releases only after two clean clock edges.
   always_ff @(posedge i_Clk or negedge i_Rst_n) begin
      if (!i_Rst_n) rstSync_q <= 2'b00;
      else          rstSync_q <= {rstSync_q[0], 1'b1};
   end
   assign rstInt_n = rstSync_q[1];

   // Only the low KEEP_W payload bits can ever reach a register, so older bytes fall off the top.
   always_comb begin
      payload_d  = KEEP_W'({payload_q, bus.i_RX_Byte});
      timeoutHit = (state_q != ST_IDLE) && !bus.i_RX_DV && (timeoutCnt_q == TO_LAST);
      if ((state_q == ST_IDLE) || bus.i_RX_DV || timeoutHit) timeoutCnt_d = '0;
      else                                                     timeoutCnt_d = timeoutCnt_q + CNT_W'(1);
`ifdef UART_CMD_CHECKSUM_EN
      csumBad = (csum_q != 8'h00);
`else
      csumBad = 1'b0;
`endif
   end

   always_ff @(posedge i_Clk or negedge rstInt_n) begin
      if (!rstInt_n) begin
         state_q      <= ST_IDLE;
         addr_q       <= '0;
         payload_q    <= '0;
         byteCnt_q    <= '0;
         timeoutCnt_q <= '0;
         gains_q      <= '0;
         ctrl_q       <= '0;
         wrPulse_q    <= 1'b0;
         wrAddr_q     <= '0;
         errPulse_q   <= 1'b0;
         errCode_q    <= '0;
         ackDv_q      <= 1'b0;
         ackByte_q    <= '0;
`ifdef UART_CMD_CHECKSUM_EN
         csum_q       <= '0;
`endif
      end else begin
         wrPulse_q    <= 1'b0;
         errPulse_q   <= 1'b0;
         ackDv_q      <= 1'b0;
         timeoutCnt_q <= timeoutCnt_d;
         if (timeoutHit) begin
            errPulse_q <= 1'b1;
            errCode_q  <= ERR_CHECK;
            ackDv_q    <= 1'b1;
            ackByte_q  <= NAK_BYTE;
            state_q    <= ST_IDLE;
         end else if (bus.i_RX_DV) begin
            unique case (state_q)
               ST_IDLE: begin
                  if (bus.i_RX_Byte == SOF_BYTE) state_q <= ST_ADDR;
               end
               ST_ADDR: begin
                  addr_q    <= bus.i_RX_Byte;
                  payload_q <= '0;
                  byteCnt_q <= '0;
`ifdef UART_CMD_CHECKSUM_EN
                  csum_q    <= bus.i_RX_Byte;
`endif
                  state_q   <= ST_DATA;
               end
               ST_DATA: begin
                  payload_q <= payload_d;
                  byteCnt_q <= byteCnt_q + BC_W'(1);
`ifdef UART_CMD_CHECKSUM_EN
                  csum_q    <= csum_q ^ bus.i_RX_Byte;
                  if (byteCnt_q == DATA_LAST) state_q <= ST_CSUM;
`else
                  if (byteCnt_q == DATA_LAST) state_q <= ST_EOF;
`endif
               end
               ST_CSUM: begin
`ifdef UART_CMD_CHECKSUM_EN
                  csum_q  <= csum_q ^ bus.i_RX_Byte;
`endif
                  state_q <= ST_EOF;
               end
               ST_EOF: begin
                  // A good frame XORs to zero once its checksum byte is folded in.
                  ackDv_q <= 1'b1;
                  state_q <= ST_IDLE;
                  if ((bus.i_RX_Byte != EOF_BYTE) || csumBad || (addr_q > MAX_ADDR)) begin
                     errPulse_q <= 1'b1;
                     ackByte_q  <= NAK_BYTE;
                     if (bus.i_RX_Byte != EOF_BYTE) errCode_q <= ERR_EOF;
                     else if (csumBad)              errCode_q <= ERR_CHECK;
                     else                           errCode_q <= ERR_ADDR;
                  end else begin
                     wrPulse_q <= 1'b1;
                     wrAddr_q  <= addr_q;
                     ackByte_q <= ACK_BYTE;
                     if (addr_q == 8'd0) ctrl_q <= payload_q[7:0];
                     for (int k = 1; k <= NUM_GAINS; k++) begin
                        if (addr_q == 8'(k)) gains_q[(k-1)*GAIN_W +: GAIN_W] <= payload_q[GAIN_W-1:0];
                     end
                  end
               end
               default: state_q <= ST_IDLE;
            endcase
         end
      end
   end

   assign bus.o_gains     = gains_q;
   assign bus.o_ctrl      = ctrl_q;
   assign bus.o_wr_pulse  = wrPulse_q;
   assign bus.o_wr_addr   = wrAddr_q;
   assign bus.o_err_pulse = errPulse_q;
   assign bus.o_err_code  = errCode_q;
   assign bus.o_ack_dv    = ackDv_q;
   assign bus.o_ack_byte  = ackByte_q;
endmodule

// File: doc/uart_cmd_decoder.md
Name: uart_cmd_decoder

Overview:
- Parametrised successor of the fixed 8-byte shift-register command parser in the top level.
- Consumes the byte stream from UART_RX (valid strobe + byte) and decodes framed register-write commands with a state machine.
- Drives N gain registers plus one control register for the PID block, and emits an ACK/NAK byte request toward UART_TX.
- Adds an inter-byte timeout, error reporting and per-write strobes.

Parameters:
NUM_GAINS, 3, number of gain registers (addresses 1..NUM_GAINS)
GAIN_W, 36, width of each gain register; must be <= DATA_BYTES*8
DATA_BYTES, 5, payload bytes per frame, MSB first
SOF_BYTE, 8'hAA, start-of-frame marker
EOF_BYTE, 8'hBB, end-of-frame marker
TIMEOUT_CLKS, 50000, max clocks between bytes inside a frame (1 ms at 50 MHz)

Ports:
i_Clk  in  1  system clock
i_Rst_n  in  1  asynchronous active-low reset
i_RX_DV  in  1  one-cycle strobe, byte valid
i_RX_Byte  in  8  received byte
o_gains  out  NUM_GAINS*GAIN_W  packed gains; gain k (address k) at bits [k*GAIN_W-1 : (k-1)*GAIN_W]
o_ctrl  out  8  control register (address 0); bit0 = PID reset
o_wr_pulse  out  1  one-cycle strobe on every committed write
o_wr_addr  out  8  address of last committed write
o_err_pulse  out  1  one-cycle strobe on a rejected frame
o_err_code  out  2  1 = bad address, 2 = bad EOF, 3 = timeout/checksum; holds until next error
o_ack_dv  out  1  one-cycle request to transmit o_ack_byte
o_ack_byte  out  8  8'h06 = ACK, 8'h15 = NAK

Behaviour:
- Reset (async assert, synchronous release): all outputs and registers are 0; state IDLE; timeout counter 0.
- States: IDLE -> ADDR -> DATA -> [CSUM] -> EOF -> IDLE.
- IDLE: a byte equal to SOF_BYTE enters ADDR. Any other byte is ignored, with no error.
- ADDR: latch the address byte and go to DATA; clear the payload shift register and the byte counter.
- DATA: shift each byte in at the LSB end. After DATA_BYTES bytes go to CSUM if enabled, otherwise to EOF.
- SOF_BYTE and EOF_BYTE values inside ADDR/DATA are treated as plain data. There is no resync.
- EOF state, on the next byte, checks in priority order:
  1. byte != EOF_BYTE -> error 2;
  2. checksum mismatch -> error 3;
  3. address > NUM_GAINS -> error 1;
  4. otherwise commit.
- The EOF state always returns to IDLE after that byte.
- Commit happens on the clock edge after the EOF byte's i_RX_DV:
  - address 0 loads payload[7:0] into o_ctrl;
  - address k loads payload[GAIN_W-1:0] into gain k (upper payload bits discarded);
  - o_wr_pulse = 1 and o_wr_addr = address for one cycle;
  - o_ack_dv = 1 with o_ack_byte = 8'h06.
- Error: no register changes; o_err_pulse = 1 for one cycle; o_err_code updated; o_ack_dv = 1 with o_ack_byte = 8'h15. Same cycle position as a commit.
- Timeout:
  - Counter runs in every state except IDLE and clears on each i_RX_DV.
  - On reaching TIMEOUT_CLKS-1 without a byte: error 3 with NAK, then return to IDLE.
  - If a byte arrives in the same cycle the count expires, the byte wins and no timeout occurs.
- Total latency from EOF strobe to wr/err/ack strobes: 1 clock.
- Back-to-back frames are supported; a SOF may arrive the cycle after EOF.
- Reset asserted mid-frame aborts the frame with no strobes; registers return to 0.

Optional Feature:
- Macro UART_CMD_CHECKSUM_EN.
- Defined: a CSUM byte sits between the last data byte and EOF. It must equal the XOR of the address byte and all payload bytes; mismatch -> error 3.
- Undefined: there is no CSUM state, the frame is DATA_BYTES+3 bytes, and error 3 means timeout only.

Test Plan:
- Feature off; send AA 02 0F 12 34 56 78 BB -> o_wr_pulse 1 cycle, o_wr_addr = 2, gain2 = 36'hF12345678, o_ack_byte = 06, other gains 0.
- Send AA 00 00 00 00 00 01 BB, then AA 00 00 00 00 00 00 BB -> o_ctrl[0] goes 1 then 0, two ACKs.
- Send AA 07 00 00 00 00 01 BB -> o_err_code = 1, NAK, no o_wr_pulse, gains unchanged.
- Send AA 01 01 02 03 04 05 CC -> o_err_code = 2, NAK; then a valid frame immediately after -> ACK and write.
- Send AA 01 11 then idle for TIMEOUT_CLKS cycles -> o_err_code = 3, NAK exactly once, state IDLE; a following full frame is accepted.
- Feature on; send AA 01 00 00 00 00 05 04 BB (checksum 01^05 = 04) -> ACK, gain1 = 5. Same frame with checksum 00 -> error 3. Separately, assert i_Rst_n low mid-frame -> all outputs 0, no strobes.
